// File: rtl/pmc_pkg.sv
// Shared definitions for the performance-counter readout block.
// Optional feature macro: PMC_READER_CHECKSUM_EN adds a trailing checksum byte.
package pmc_pkg;

    localparam int PMC_WORDS      = 4;
    localparam int PMC_DATA_BYTES = 16;
    localparam int PMC_SNAP_W     = PMC_WORDS * 32;

    localparam logic [7:0] PMC_HEADER_DEFAULT = 8'hA5;

`ifdef PMC_READER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_CHECK,
        ST_DONE
    } pmc_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_DONE
    } pmc_state_e;
`endif

    // Byte idx of the snapshot; byte 0 is the least-significant byte of word 0.
    function automatic logic [7:0] pmc_byte_sel(input logic [PMC_SNAP_W-1:0] snap,
                                                 input logic [3:0] idx);
        return snap[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pmc_reader_if.sv
// Byte-stream bus from the readout block to its downstream sink.
interface pmc_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pmc_snapshot.sv
// Holds the four counter words captured at the request edge.
module pmc_snapshot
    import pmc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [PMC_SNAP_W-1:0] snap_in,
    output logic [PMC_SNAP_W-1:0] snap_out
);

    logic [PMC_SNAP_W-1:0] snap_q;
    logic [PMC_SNAP_W-1:0] snap_d;

    // Next snapshot: new counter values on load, otherwise hold.
    always_comb begin
        snap_d = snap_q;
        if (load) begin
            snap_d = snap_in;
        end
    end

    // Snapshot register, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_out = snap_q;

endmodule

// File: rtl/pmc_reader.sv
// Serialises a snapshot of four 32-bit performance counters as a byte frame:
// header, 16 data bytes (LSB first per word), optional checksum byte.
// Optional feature macro: PMC_READER_CHECKSUM_EN.
module pmc_reader
    import pmc_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = PMC_HEADER_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         stall_count,
    input  logic [31:0]         instr_cycle_count,
    input  logic [31:0]         arith_count,
    input  logic [31:0]         mem_access_count,
    input  logic                req_in,
    pmc_reader_if.master        bus,
    output logic                busy,
    output logic                done
);

    pmc_state_e            state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic                  snap_load;
    logic [PMC_SNAP_W-1:0] snap;
    logic [7:0]            cur_byte;
    logic [7:0]            out_data_c;
    logic                  out_valid_c;
`ifdef PMC_READER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    pmc_snapshot u_snapshot (
        .clk      (clk),
        .reset    (reset),
        .load     (snap_load),
        .snap_in  ({mem_access_count, arith_count, instr_cycle_count, stall_count}),
        .snap_out (snap)
    );

    assign cur_byte = pmc_byte_sel(snap, idx_q);

    // Frame sequencing: state/index advance only on an accepted byte.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_load   = 1'b0;
        out_data_c  = 8'h00;
        out_valid_c = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
`ifdef PMC_READER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (req_in) begin
                    snap_load = 1'b1;
                    idx_d     = 4'd0;
                    state_d   = ST_HEADER;
`ifdef PMC_READER_CHECKSUM_EN
                    csum_d    = 8'h00;
`endif
                end
            end
            ST_HEADER: begin
                out_valid_c = 1'b1;
                out_data_c  = HEADER_BYTE;
                if (bus.out_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                out_valid_c = 1'b1;
                out_data_c  = cur_byte;
                if (bus.out_ready) begin
                    idx_d = idx_q + 4'd1;
`ifdef PMC_READER_CHECKSUM_EN
                    csum_d = csum_q + cur_byte;
                    if (idx_q == 4'(PMC_DATA_BYTES - 1)) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (idx_q == 4'(PMC_DATA_BYTES - 1)) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef PMC_READER_CHECKSUM_EN
            ST_CHECK: begin
                out_valid_c = 1'b1;
                out_data_c  = csum_q;
                if (bus.out_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
`ifdef PMC_READER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef PMC_READER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.out_data  = out_data_c;
    assign bus.out_valid = out_valid_c;

endmodule

// File: tb/tb_pmc_reader.sv
// Directed bench for pmc_reader: nominal frames, back-pressure, snapshot
// isolation, mid-frame reset and back-to-back requests.
module tb_pmc_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stall_count, instr_cycle_count, arith_count, mem_access_count;
    logic        req_in;
    logic        busy, done;
    int          total = 0;
    int          bad   = 0;

    pmc_reader_if bus ();

    pmc_reader dut (
        .clk               (clk),
        .reset             (reset),
        .stall_count       (stall_count),
        .instr_cycle_count (instr_cycle_count),
        .arith_count       (arith_count),
        .mem_access_count  (mem_access_count),
        .req_in            (req_in),
        .bus               (bus.master),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        stall_count       = stall_count + 1;
        instr_cycle_count = instr_cycle_count + 1;
        arith_count       = arith_count + 1;
        mem_access_count  = mem_access_count + 1;
    endtask

    // Expected frame byte i (0 = header) from the four captured words.
    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] w0,
                                            input logic [31:0] w1, input logic [31:0] w2,
                                            input logic [31:0] w3);
        logic [31:0] w;
        int          k;
        if (i == 0) return 8'hA5;
        k = i - 1;
        case (k / 4)
            0:       w = w0;
            1:       w = w1;
            2:       w = w2;
            default: w = w3;
        endcase
        return w[(k % 4) * 8 +: 8];
    endfunction

    // Request one frame and check every byte; optional stall, counter
    // drift, mid-frame abort, and request held high into the next frame.
    task automatic run_frame(input int stall_at, input int stall_len, input bit incr,
                             input int abort_at, input bit hold_req);
        logic [31:0] s0, s1, s2, s3;
        logic [7:0]  e, sum;
        int          nbytes;
        s0 = stall_count; s1 = instr_cycle_count; s2 = arith_count; s3 = mem_access_count;
        nbytes = 17;
`ifdef PMC_READER_CHECKSUM_EN
        nbytes = 18;
`endif
        sum = 8'h00;
        req_in = 1'b1;
        tick();
        if (!hold_req) req_in = 1'b0;
        if (incr) bump();
        for (int i = 0; i < nbytes; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_valid", bus.out_valid, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_data", bus.out_data, 8'h00);
                tick();
                chk("abort_done", done, 1'b0);
                chk("abort_busy_next", busy, 1'b0);
                reset = 1'b0;
                tick();
                chk("abort_idle_valid", bus.out_valid, 1'b0);
                return;
            end
            e = (i <= 16) ? exp_byte(i, s0, s1, s2, s3) : sum;
            if (i >= 1 && i <= 16) sum = sum + e;
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (stall_len) begin
                    chk("stall_valid", bus.out_valid, 1'b1);
                    chk("stall_data", bus.out_data, e);
                    tick();
                    if (incr) bump();
                end
                bus.out_ready = 1'b1;
            end
            chk($sformatf("byte%0d_valid", i), bus.out_valid, 1'b1);
            chk($sformatf("byte%0d_data", i), bus.out_data, e);
            chk($sformatf("byte%0d_busy", i), busy, 1'b1);
            chk($sformatf("byte%0d_done", i), done, 1'b0);
            tick();
            if (incr) bump();
        end
        chk("done_pulse", done, 1'b1);
        chk("done_valid", bus.out_valid, 1'b0);
        chk("done_busy", busy, 1'b1);
        tick();
        chk("idle_done", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", bus.out_valid, 1'b0);
        if (hold_req) begin
            tick();
            chk("b2b_header_valid", bus.out_valid, 1'b1);
            chk("b2b_header_data", bus.out_data, 8'hA5);
            chk("b2b_busy", busy, 1'b1);
        end
    endtask

    initial begin
        reset             = 1'b1;
        req_in            = 1'b0;
        bus.out_ready     = 1'b1;
        stall_count       = 32'h11223344;
        instr_cycle_count = 32'h55667788;
        arith_count       = 32'h99AABBCC;
        mem_access_count  = 32'hDDEEFF00;
        tick();
        tick();
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        tick();
        chk("idle_no_req_busy", busy, 1'b0);

        // Nominal frame with the reference counter values.
        run_frame(-1, 0, 1'b0, -1, 1'b0);

        // Back-pressure for three cycles on frame byte 5 (0x88).
        run_frame(5, 3, 1'b0, -1, 1'b0);

        // Counters keep moving after the request edge.
        run_frame(-1, 0, 1'b1, -1, 1'b0);

        // Reset at byte 7, then a fresh frame with new values.
        stall_count       = 32'hFFFFFFFF;
        instr_cycle_count = 32'h00000000;
        arith_count       = 32'h80000001;
        mem_access_count  = 32'h12345678;
        run_frame(-1, 0, 1'b0, 7, 1'b0);
        run_frame(-1, 0, 1'b0, -1, 1'b0);

        // Request held high: DONE, one IDLE cycle, then the next header.
        run_frame(-1, 0, 1'b0, -1, 1'b1);
        req_in = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("final_idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
